// File: rtl/add_approx_pkg.sv
// add_approx_pkg: shared mode encoding and parameter legality limits for the approximate adder
package add_approx_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } mode_e;

   localparam int WIDTH_MIN  = 4;
   localparam int WIDTH_MAX  = 32;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;
   localparam int CNT_W_MIN  = 1;
   localparam int CNT_W_MAX  = 32;

endpackage

// File: rtl/loa_core.sv
// loa_core: lower-part OR adder producing both the approximate and the exact sum
module loa_core #(
   parameter int WIDTH       = 8,
   parameter int APPROX_BITS = 2
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH:0]   approx_o,
   output logic [WIDTH:0]   exact_o
);

   assign exact_o = {1'b0, a_i} + {1'b0, b_i};

   if (APPROX_BITS == 0) begin : g_exact
      assign approx_o = exact_o;
   end else begin : g_loa
      localparam int K = APPROX_BITS;
      logic             g;
      logic [WIDTH-K:0] hi;
      // the top OR'd bit pair still generates a carry into the exact upper part
      assign g        = a_i[K-1] & b_i[K-1];
      assign hi       = {1'b0, a_i[WIDTH-1:K]} + {1'b0, b_i[WIDTH-1:K]} + {{(WIDTH-K){1'b0}}, g};
      assign approx_o = {hi, a_i[K-1:0] | b_i[K-1:0]};
   end

endmodule

// File: rtl/add_approx_pipe.sv
// add_approx_pipe: pipelined exact/approximate adder with valid-ready handshake and error statistics
module add_approx_pipe
   import add_approx_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int APPROX_BITS = 2,
   parameter int STAGES      = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic [WIDTH:0]   sum_exact,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] txn_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH:0]   max_err
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || APPROX_BITS < 0 || APPROX_BITS > WIDTH - 1 ||
       STAGES < STAGES_MIN || STAGES > STAGES_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_params
      $error("add_approx_pipe: illegal parameter combination");
   end

   localparam int L = STAGES - 1;

   logic [WIDTH:0]              approx_w;
   logic [WIDTH:0]              exact_w;
   logic                        adv;
   logic                        xfer;
   logic                        miss;
   logic [WIDTH:0]              diff;
   logic [STAGES-1:0]           vld_q, vld_d;
   mode_e [STAGES-1:0]          mode_q, mode_d;
   logic [STAGES-1:0][WIDTH:0]  sum_q, sum_d;
   logic [STAGES-1:0][WIDTH:0]  ex_q, ex_d;
   logic [CNT_W-1:0]            txn_q, txn_d;
   logic [CNT_W-1:0]            err_q, err_d;
   logic [WIDTH:0]              max_q, max_d;

   loa_core #(
      .WIDTH      (WIDTH),
      .APPROX_BITS(APPROX_BITS)
   ) u_loa (
      .a_i     (a),
      .b_i     (b),
      .approx_o(approx_w),
      .exact_o (exact_w)
   );

   // the whole pipe moves as one; a held result in the last stage freezes every stage
   assign adv  = !vld_q[L] || out_ready;
   assign xfer = vld_q[L] && out_ready;
   assign diff = (sum_q[L] > ex_q[L]) ? sum_q[L] - ex_q[L] : ex_q[L] - sum_q[L];
   assign miss = (mode_q[L] == MODE_APPROX) && (diff != '0);

   // shift the stages on advance; stage 0 captures the result chosen by the transaction's own mode
   always_comb begin
      vld_d  = vld_q;
      mode_d = mode_q;
      sum_d  = sum_q;
      ex_d   = ex_q;
      if (adv) begin
         for (int i = STAGES - 1; i > 0; i--) begin
            vld_d[i]  = vld_q[i-1];
            mode_d[i] = mode_q[i-1];
            sum_d[i]  = sum_q[i-1];
            ex_d[i]   = ex_q[i-1];
         end
         vld_d[0]  = in_valid;
         mode_d[0] = mode_e'(mode);
         sum_d[0]  = (mode_e'(mode) == MODE_APPROX) ? approx_w : exact_w;
         ex_d[0]   = exact_w;
      end
   end

   // saturating statistics; a clear overrides any transfer in the same cycle
   always_comb begin
      txn_d = stat_clr ? '0 : (xfer && txn_q != '1) ? txn_q + CNT_W'(1) : txn_q;
      err_d = stat_clr ? '0 : (xfer && miss && err_q != '1) ? err_q + CNT_W'(1) : err_q;
      max_d = stat_clr ? '0 : (xfer && miss && diff > max_q) ? diff : max_q;
   end

   // state registers; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         mode_q <= {STAGES{MODE_EXACT}};
         sum_q  <= '0;
         ex_q   <= '0;
         txn_q  <= '0;
         err_q  <= '0;
         max_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         mode_q <= mode_d;
         sum_q  <= sum_d;
         ex_q   <= ex_d;
         txn_q  <= txn_d;
         err_q  <= err_d;
         max_q  <= max_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[L];
   assign sum       = sum_q[L];
   assign sum_exact = ex_q[L];
   assign txn_cnt   = txn_q;
   assign err_cnt   = err_q;
   assign max_err   = max_q;

endmodule

// File: tb/tb_add_approx_pipe.sv
// tb_add_approx_pipe: directed and random checks of add_approx_pipe against a scoreboard model
module tb_add_approx_pipe;

   localparam int W   = 8;
   localparam int STG = 2;

   typedef struct {
      int s;
      int e;
      bit m;
   } exp_t;

   logic           clk = 0;
   logic           rst;
   logic           in_valid, in_ready, out_valid, out_ready, mode, stat_clr;
   logic [W-1:0]   a, b;
   logic [W:0]     sum, sum_exact, max_err;
   logic [15:0]    txn_cnt, err_cnt;
   logic           s_in_ready, s_out_valid;
   logic [W:0]     s_sum, s_sum_exact, s_max;
   logic [3:0]     s_txn, s_err;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0, n_out = 0;
   int   m_txn = 0, m_err = 0, m_max = 0;
   bit   mon_en = 0;

   always #5 clk = ~clk;

   add_approx_pipe #(.WIDTH(W), .APPROX_BITS(2), .STAGES(STG), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .sum_exact(sum_exact),
      .stat_clr(stat_clr), .txn_cnt(txn_cnt), .err_cnt(err_cnt), .max_err(max_err)
   );

   add_approx_pipe #(.WIDTH(W), .APPROX_BITS(2), .STAGES(STG), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .mode(mode),
      .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .sum_exact(s_sum_exact),
      .stat_clr(stat_clr), .txn_cnt(s_txn), .err_cnt(s_err), .max_err(s_max)
   );

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // reference: exact sum, or OR of the two low bits plus exact upper sum with carry from bit 1
   function automatic int ref_sum(input int x, input int y, input bit m);
      int lo, hi;
      if (!m) return x + y;
      lo = (x | y) & 3;
      hi = (x >> 2) + (y >> 2) + ((x >> 1) & (y >> 1) & 1);
      return hi * 4 + lo;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, obs, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: checks outputs and statistics every cycle, records transfers due at the next edge
   always @(negedge clk) begin
      if (mon_en) begin
         chk("txn_cnt", txn_cnt, sat(m_txn, 65535));
         chk("err_cnt", err_cnt, sat(m_err, 65535));
         chk("max_err", max_err, m_max);
         chk("sat_txn_cnt", s_txn, sat(m_txn, 15));
         chk("sat_err_cnt", s_err, sat(m_err, 15));
         chk("sat_max_err", s_max, m_max);
         chk("in_ready", in_ready, !out_valid || out_ready);
         chk("sat_in_ready", s_in_ready, !s_out_valid || out_ready);
         if (rst) begin
            q.delete();
            m_txn = 0; m_err = 0; m_max = 0;
         end else begin
            if (q.size() == 0) begin
               chk("out_valid_without_input", out_valid, 0);
               chk("sat_out_valid_without_input", s_out_valid, 0);
            end else if (out_valid) begin
               chk("sum", sum, q[0].s);
               chk("sum_exact", sum_exact, q[0].e);
               chk("sat_sum", s_sum, q[0].s);
            end
            if (stat_clr) begin
               m_txn = 0; m_err = 0; m_max = 0;
            end
            if (out_valid && out_ready && q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               n_out++;
               if (!stat_clr) begin
                  m_txn++;
                  if (e.m && e.s != e.e) begin
                     m_err++;
                     if ((e.s > e.e ? e.s - e.e : e.e - e.s) > m_max) m_max = (e.s > e.e ? e.s - e.e : e.e - e.s);
                  end
               end
            end
            if (in_valid && in_ready) q.push_back('{ref_sum(int'(a), int'(b), mode), int'(a) + int'(b), mode});
         end
      end
   end

   task automatic one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                      input int want_sum, input int want_ex);
      int lat;
      a = ta; b = tb_v; mode = tm; in_valid = 1; out_ready = 1;
      cyc();
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         cyc();
         lat++;
      end
      chk("latency", lat, STG);
      chk("dir_sum", sum, want_sum);
      chk("dir_sum_exact", sum_exact, want_ex);
      cyc();
   endtask

   task automatic drain();
      int k;
      k = 0;
      in_valid = 0; out_ready = 1;
      while ((out_valid || q.size() != 0) && k < 50) begin
         cyc();
         k++;
      end
      if (k == 50) chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      int sent, base;
      bit saw_full;
      rst = 1; in_valid = 0; out_ready = 0; stat_clr = 0; a = 0; b = 0; mode = 0;
      repeat (3) cyc();
      mon_en = 1;
      rst = 0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_sum_exact", sum_exact, 0);
      chk("rst_txn", txn_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_max", max_err, 0);

      one(8'd3, 8'd1, 1'b1, 3, 4);
      chk("t1_err", err_cnt, 1);
      chk("t1_max", max_err, 1);
      one(8'd2, 8'd2, 1'b1, 6, 4);
      chk("t2_err", err_cnt, 2);
      chk("t2_max", max_err, 2);
      one(8'd255, 8'd255, 1'b0, 510, 510);
      chk("t3_err", err_cnt, 2);
      chk("t3_txn", txn_cnt, 3);

      stat_clr = 1;
      cyc();
      stat_clr = 0;
      sent = 0; saw_full = 0; base = n_out;
      for (int c = 0; c < 60 && sent < 8; c++) begin
         a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom); in_valid = 1;
         out_ready = !(c >= 3 && c < 8);
         #1;
         if (!in_ready) saw_full = 1;
         else sent++;
         cyc();
      end
      drain();
      chk("stream_stall_seen", saw_full, 1);
      chk("stream_delivered", n_out - base, 8);
      chk("stream_txn", txn_cnt, 8);

      base = n_out;
      a = 8'd3; b = 8'd1; mode = 1; in_valid = 1; out_ready = 1;
      cyc();
      in_valid = 0;
      for (int k = 0; k < 10 && !out_valid; k++) cyc();
      stat_clr = 1;
      cyc();
      stat_clr = 0;
      chk("clr_txn", txn_cnt, 0);
      chk("clr_err", err_cnt, 0);
      chk("clr_max", max_err, 0);
      chk("clr_delivered", n_out - base, 1);

      for (int c = 0; c < 300; c++) begin
         a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         stat_clr = $urandom_range(0, 31) == 0;
         cyc();
      end
      stat_clr = 0;
      drain();

      a = 8'd5; b = 8'd6; mode = 1; in_valid = 1; out_ready = 0;
      cyc();
      a = 8'd7;
      cyc();
      in_valid = 0; rst = 1;
      cyc();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_txn", txn_cnt, 0);
      chk("mid_rst_err", err_cnt, 0);
      rst = 0;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("mid_rst_no_stale", out_valid, 0);
      end

      stat_clr = 1;
      cyc();
      stat_clr = 0;
      a = 8'd3; b = 8'd1; mode = 1; in_valid = 1; out_ready = 1;
      repeat (20) cyc();
      drain();
      chk("sat4_txn", s_txn, 15);
      chk("sat4_err", s_err, 15);
      chk("sat4_max", s_max, 1);
      chk("full_txn", txn_cnt, 20);
      chk("full_err", err_cnt, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/add_approx_pipe.md
ADD_APPROX_PIPE -- requirements
Module: add_approx_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal 4..32.
REQ-002 Parameter APPROX_BITS, default 2, low bits computed by lower-part OR approximation; legal 0..WIDTH-1; 0 means always exact.
REQ-003 Parameter STAGES, default 2, pipeline depth in cycles; legal 1..4.
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  operands valid; in_ready  out  1  block accepts operands.
REQ-008 a, b  in  WIDTH  unsigned operands; mode  in  1  0=exact, 1=approximate.
REQ-009 out_valid  out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-010 sum  out  WIDTH+1  result; sum_exact  out  WIDTH+1  exact a+b for the same transaction.
REQ-011 stat_clr  in  1  clear statistics; txn_cnt, err_cnt  out  CNT_W; max_err  out  WIDTH+1.

Function
REQ-012 Exact mode SHALL give sum = a + b, full WIDTH+1 bits, no truncation.
REQ-013 Approx mode SHALL give sum[K-1:0] = a[K-1:0] | b[K-1:0] (K=APPROX_BITS), and sum[WIDTH:K] = a[W-1:K] + b[W-1:K] + g, g = a[K-1] & b[K-1] (g=0 when K=0).
REQ-014 Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-015 Pipeline SHALL advance when last stage empty or out_ready=1; in_ready SHALL equal that advance condition; stall freezes every stage.
REQ-016 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one transaction per cycle.
REQ-017 mode SHALL be captured per transaction and travel with its operands; mixed-mode streams allowed.
REQ-018 sum/sum_exact SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 On each output transfer: txn_cnt += 1; if mode=1 and sum != sum_exact, err_cnt += 1 and max_err = max(max_err, |sum - sum_exact|).
REQ-020 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 stat_clr SHALL zero txn_cnt, err_cnt, max_err next cycle; if coincident with an output transfer, clear wins and that transfer is not counted; the transfer itself proceeds.
REQ-022 Bubbles (in_valid=0) SHALL propagate as invalid stages; out_valid never asserts without a matching input transfer.

Reset
REQ-023 rst SHALL clear all stage valid bits, out_valid=0, sum=0, sum_exact=0, txn_cnt=0, err_cnt=0, max_err=0.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 rst mid-operation SHALL discard all in-flight transactions; none appear at the output afterward.

Structure
REQ-026 Shared package add_approx_pkg SHALL hold the mode enum (MODE_EXACT=0, MODE_APPROX=1) and parameter legality limits.
REQ-027 One combinational sub-module loa_core (WIDTH, APPROX_BITS) SHALL compute approx and exact sums; add_approx_pipe holds pipeline, handshake and statistics.
REQ-028 Illegal parameters SHALL fail elaboration.

Verification (WIDTH=8, APPROX_BITS=2, STAGES=2)
REQ-029 a=3,b=1,mode=1 -> sum=3, sum_exact=4, out_valid 2 cycles after accept, err_cnt=1, max_err=1.
REQ-030 a=2,b=2,mode=1 -> sum=6, sum_exact=4, max_err=2; a=255,b=255,mode=0 -> sum=510, err_cnt unchanged.
REQ-031 Back-to-back 8 transactions with out_ready held 0 for 5 cycles mid-stream -> in_ready=0 while full, no loss/duplication, order preserved, txn_cnt=8.
REQ-032 stat_clr asserted in same cycle as an erroring output transfer -> all stats 0 next cycle, result still delivered.
REQ-033 rst asserted with 2 transactions in flight -> out_valid=0 next cycle, stats 0, no stale result later; in_ready=1 after release.
REQ-034 CNT_W=4, 20 erroring approx transactions -> err_cnt and txn_cnt stick at 15.
